// File: rtl/ctrl_mc.sv
// ctrl_mc: byte-oriented command controller for servo channels and an
// ultrasonic ranger. It decodes init/servo/trigger frames from a serial
// receiver, keeps per-channel positions, runs range measurements and
// streams replies back to a serial transmitter. All outputs are registered.
module ctrl_mc #(
    parameter int unsigned N_SERVO = 2,
    parameter int unsigned POS_LEN = 8,
    parameter int unsigned POS_DEF = 150,
    parameter int unsigned CAP_LEN = 16,
    parameter int unsigned RTO_CYC = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic [N_SERVO*POS_LEN-1:0] servo_pos,
    output logic                       rng_en,
    input  logic                       rng_done,
    input  logic [CAP_LEN-1:0]         rng_len,
    output logic [7:0]                 err_cnt
);

    localparam int unsigned        NB      = CAP_LEN / 8;
    localparam int unsigned        CW      = $clog2(RTO_CYC + 1);
    localparam logic [POS_LEN-1:0] P_DEF   = POS_LEN'(POS_DEF);
    localparam logic [CW-1:0]      TO_LAST = CW'(RTO_CYC - 1);
    localparam logic [2:0]         LAST_RG = 3'(NB + 1);

    localparam logic [7:0] CMD_INIT  = 8'h00;
    localparam logic [7:0] CMD_SERVO = 8'h03;
    localparam logic [7:0] CMD_TRIG  = 8'h0C;
    localparam logic [7:0] RSP_ACK   = 8'hAA;
    localparam logic [7:0] RSP_SVOK  = 8'hAB;
    localparam logic [7:0] RSP_RNG   = 8'hAE;
    localparam logic [7:0] RSP_NAK   = 8'h55;

    typedef enum logic [3:0] {
        BOOT,
        IDLE,
        SV_CH,
        SV_POS,
        SV_SUM,
        RG_START,
        RG_WAIT,
        TX_BYTE,
        TX_WAIT
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic                       r_tx_send, w_tx_send_nxt;
    logic [7:0]                 r_tx_data, w_tx_data_nxt;
    logic                       r_rng_en, w_rng_en_nxt;
    logic [7:0]                 r_err, w_err_nxt;
    logic [N_SERVO*POS_LEN-1:0] r_servo_pos, w_pos_nxt;
    logic [7:0]                 r_ch, w_ch_nxt;
    logic [7:0]                 r_pos, w_pos_b_nxt;
    logic [CW-1:0]              r_cnt, w_cnt_nxt;
    logic [7:0]                 r_tx_head, w_head_nxt;
    logic [2:0]                 r_tx_last, w_last_nxt;
    logic [2:0]                 r_tx_idx, w_idx_nxt;
    logic                       r_guard, w_guard_nxt;
    logic                       r_armed, w_armed_nxt;
    logic [CAP_LEN-1:0]         r_rng_len, w_len_nxt;

    logic                       w_err_inc;
    logic                       w_reply;
    logic [7:0]                 w_reply_head;
    logic [7:0]                 w_len_byte;
    logic [7:0]                 w_len_xor;
    logic [7:0]                 w_tx_byte;
    logic                       w_frame_ok;

    // Select the reply byte at the current index: head, length bytes MSB first, then their XOR
    always_comb begin
        w_len_xor  = '0;
        w_len_byte = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_len_xor = w_len_xor ^ r_rng_len[b*8 +: 8];
            if (32'(r_tx_idx) == NB - b) begin
                w_len_byte = r_rng_len[b*8 +: 8];
            end
        end
        if (r_tx_idx == 3'd0) begin
            w_tx_byte = r_tx_head;
        end else if (32'(r_tx_idx) <= NB) begin
            w_tx_byte = w_len_byte;
        end else begin
            w_tx_byte = w_len_xor;
        end
    end

    assign w_frame_ok = (32'(r_ch) < N_SERVO) && ((CMD_SERVO ^ r_ch ^ r_pos) == rx_data);

    // Next-state and next-output logic for the controller FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_send_nxt = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_rng_en_nxt  = 1'b0;
        w_pos_nxt     = r_servo_pos;
        w_ch_nxt      = r_ch;
        w_pos_b_nxt   = r_pos;
        w_cnt_nxt     = r_cnt;
        w_head_nxt    = r_tx_head;
        w_last_nxt    = r_tx_last;
        w_idx_nxt     = r_tx_idx;
        w_guard_nxt   = r_guard;
        w_armed_nxt   = r_armed;
        w_len_nxt     = r_rng_len;
        w_err_inc     = 1'b0;
        w_reply       = 1'b0;
        w_reply_head  = RSP_NAK;

        unique case (r_state)
            BOOT: begin
                w_err_inc    = rx_valid;
                w_reply      = 1'b1;
                w_reply_head = RSP_ACK;
            end
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_INIT: begin
                            for (int unsigned i = 0; i < N_SERVO; i++) begin
                                w_pos_nxt[i*POS_LEN +: POS_LEN] = P_DEF;
                            end
                            w_reply      = 1'b1;
                            w_reply_head = RSP_ACK;
                        end
                        CMD_SERVO: begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = SV_CH;
                        end
                        CMD_TRIG: begin
                            w_rng_en_nxt = 1'b1;
                            w_state_nxt  = RG_START;
                        end
                        default: begin
                            w_err_inc    = 1'b1;
                            w_reply      = 1'b1;
                            w_reply_head = RSP_NAK;
                        end
                    endcase
                end
            end
            SV_CH, SV_POS, SV_SUM: begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                if (rx_valid) begin
                    w_cnt_nxt = '0;
                    if (r_state == SV_CH) begin
                        w_ch_nxt    = rx_data;
                        w_state_nxt = SV_POS;
                    end else if (r_state == SV_POS) begin
                        w_pos_b_nxt = rx_data;
                        w_state_nxt = SV_SUM;
                    end else if (w_frame_ok) begin
                        for (int unsigned i = 0; i < N_SERVO; i++) begin
                            if (r_ch == 8'(i)) begin
                                w_pos_nxt[i*POS_LEN +: POS_LEN] = r_pos[POS_LEN-1:0];
                            end
                        end
                        w_reply      = 1'b1;
                        w_reply_head = RSP_SVOK;
                    end else begin
                        w_err_inc    = 1'b1;
                        w_reply      = 1'b1;
                        w_reply_head = RSP_NAK;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_err_inc    = 1'b1;
                    w_reply      = 1'b1;
                    w_reply_head = RSP_NAK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RG_START: begin
                w_err_inc   = rx_valid;
                // A result already showing at start is stale: wait for it to drop first
                w_armed_nxt = ~rng_done;
                w_state_nxt = RG_WAIT;
            end
            RG_WAIT: begin
                w_err_inc = rx_valid;
                if (r_armed && rng_done) begin
                    w_len_nxt   = rng_len;
                    w_head_nxt  = RSP_RNG;
                    w_last_nxt  = LAST_RG;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = TX_BYTE;
                end else if (!rng_done) begin
                    w_armed_nxt = 1'b1;
                end
            end
            TX_BYTE: begin
                w_err_inc = rx_valid;
                if (!tx_busy) begin
                    w_tx_send_nxt = 1'b1;
                    w_tx_data_nxt = w_tx_byte;
                    w_guard_nxt   = 1'b1;
                    w_state_nxt   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                w_err_inc = rx_valid;
                if (r_guard) begin
                    w_guard_nxt = 1'b0;
                end else if (!tx_busy) begin
                    if (r_tx_idx == r_tx_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt   = r_tx_idx + 3'd1;
                        w_state_nxt = TX_BYTE;
                    end
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (w_reply) begin
            w_head_nxt  = w_reply_head;
            w_last_nxt  = 3'd0;
            w_idx_nxt   = 3'd0;
            w_state_nxt = TX_BYTE;
        end

        w_err_nxt = (w_err_inc && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= BOOT;
            r_tx_send <= 1'b0;
            r_tx_data <= '0;
            r_rng_en  <= 1'b0;
            r_err     <= '0;
            for (int unsigned i = 0; i < N_SERVO; i++) begin
                r_servo_pos[i*POS_LEN +: POS_LEN] <= P_DEF;
            end
            r_ch      <= '0;
            r_pos     <= '0;
            r_cnt     <= '0;
            r_tx_head <= '0;
            r_tx_last <= '0;
            r_tx_idx  <= '0;
            r_guard   <= 1'b0;
            r_armed   <= 1'b0;
            r_rng_len <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_send   <= w_tx_send_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_rng_en    <= w_rng_en_nxt;
            r_err       <= w_err_nxt;
            r_servo_pos <= w_pos_nxt;
            r_ch        <= w_ch_nxt;
            r_pos       <= w_pos_b_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx_head   <= w_head_nxt;
            r_tx_last   <= w_last_nxt;
            r_tx_idx    <= w_idx_nxt;
            r_guard     <= w_guard_nxt;
            r_armed     <= w_armed_nxt;
            r_rng_len   <= w_len_nxt;
        end
    end

    assign tx_send   = r_tx_send;
    assign tx_data   = r_tx_data;
    assign rng_en    = r_rng_en;
    assign err_cnt   = r_err;
    assign servo_pos = r_servo_pos;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed testbench for ctrl_mc with a simple serial_t busy model.
module tb_ctrl_mc;

    localparam int unsigned RTO = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic [15:0] servo_pos;
    logic        rng_en;
    logic        rng_done;
    logic [15:0] rng_len;
    logic [7:0]  err_cnt;

    logic        busy_force;
    int          busy_cnt;
    logic [7:0]  tx_log [2048];
    int          tx_total;
    int          rng_pulses;
    int          viol;

    int          n_tests;
    int          n_fail;

    ctrl_mc #(
        .N_SERVO(2),
        .POS_LEN(8),
        .POS_DEF(150),
        .CAP_LEN(16),
        .RTO_CYC(RTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .servo_pos(servo_pos),
        .rng_en   (rng_en),
        .rng_done (rng_done),
        .rng_len  (rng_len),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0) || busy_force;

    // serial_t model: busy for 4 cycles after each send; logs sent bytes
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (tx_send) begin
            busy_cnt <= 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (tx_send) begin
            if (tx_total < 2048) tx_log[tx_total] <= tx_data;
            tx_total <= tx_total + 1;
            if (tx_busy) viol <= viol + 1;
        end
        if (rng_en) rng_pulses <= rng_pulses + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, output bit ok);
        int cyc;
        cyc = 0;
        while (tx_total < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        ok = (tx_total >= target);
    endtask

    task automatic test_reset();
        int mark;
        bit ok;
        rst = 1'b1;
        settle(3);
        n_tests++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_tests++; if (rng_en !== 1'b0) begin n_fail++; $display("FAIL reset_rng_en: got %b want 0", rng_en); end
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        n_tests++; if (servo_pos !== 16'h9696) begin n_fail++; $display("FAIL reset_pos: got %h want 9696", servo_pos); end
        mark = tx_total;
        rst = 1'b0;
        wait_tx(mark + 1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL boot_timeout: got %0d bytes want 1", tx_total - mark); end
        settle(30);
        n_tests++; if (tx_total !== mark + 1) begin n_fail++; $display("FAIL boot_count: got %0d want 1", tx_total - mark); end
        n_tests++; if (tx_log[mark] !== 8'hAA) begin n_fail++; $display("FAIL boot_byte: got %h want aa", tx_log[mark]); end
        n_tests++; if (servo_pos !== 16'h9696) begin n_fail++; $display("FAIL boot_pos: got %h want 9696", servo_pos); end
    endtask

    task automatic test_servo_ok();
        int mark;
        bit ok;
        mark = tx_total;
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h64); send_byte(8'h66);
        n_tests++; if (servo_pos !== 16'h6496) begin n_fail++; $display("FAIL servo_pos: got %h want 6496", servo_pos); end
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (!ok || tx_log[mark] !== 8'hAB) begin n_fail++; $display("FAIL servo_reply: got %h want ab", tx_log[mark]); end
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL servo_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_servo_bad();
        int mark;
        bit ok;
        mark = tx_total;
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h64); send_byte(8'h00);
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (servo_pos !== 16'h6496) begin n_fail++; $display("FAIL badsum_pos: got %h want 6496", servo_pos); end
        n_tests++; if (!ok || tx_log[mark] !== 8'h55) begin n_fail++; $display("FAIL badsum_reply: got %h want 55", tx_log[mark]); end
        n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL badsum_err: got %0d want 1", err_cnt); end
        mark = tx_total;
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h64); send_byte(8'h62);
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (servo_pos !== 16'h6496) begin n_fail++; $display("FAIL badch_pos: got %h want 6496", servo_pos); end
        n_tests++; if (!ok || tx_log[mark] !== 8'h55) begin n_fail++; $display("FAIL badch_reply: got %h want 55", tx_log[mark]); end
        n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL badch_err: got %0d want 2", err_cnt); end
    endtask

    task automatic test_init_and_drop();
        int mark;
        bit ok;
        mark = tx_total;
        send_byte(8'h7F);
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (!ok || tx_log[mark] !== 8'h55) begin n_fail++; $display("FAIL unknown_reply: got %h want 55", tx_log[mark]); end
        n_tests++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL unknown_err: got %0d want 3", err_cnt); end
        mark = tx_total;
        send_byte(8'h00);
        send_byte(8'h03);
        n_tests++; if (servo_pos !== 16'h9696) begin n_fail++; $display("FAIL init_pos: got %h want 9696", servo_pos); end
        wait_tx(mark + 1, ok);
        settle(20);
        n_tests++; if (tx_total !== mark + 1 || tx_log[mark] !== 8'hAA) begin n_fail++; $display("FAIL init_reply: got %0d bytes first %h want 1 byte aa", tx_total - mark, tx_log[mark]); end
        n_tests++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL drop_err: got %0d want 4", err_cnt); end
    endtask

    task automatic test_timeout();
        int mark;
        bit ok;
        mark = tx_total;
        send_byte(8'h03); send_byte(8'h00);
        settle(RTO - 1);
        n_tests++; if (err_cnt !== 8'd4 || tx_total !== mark) begin n_fail++; $display("FAIL timeout_early: got err %0d bytes %0d want 4 0", err_cnt, tx_total - mark); end
        settle(1);
        n_tests++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL timeout_err: got %0d want 5", err_cnt); end
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (!ok || tx_log[mark] !== 8'h55) begin n_fail++; $display("FAIL timeout_reply: got %h want 55", tx_log[mark]); end
        mark = tx_total;
        send_byte(8'h03); send_byte(8'h00);
        settle(RTO - 1);
        send_byte(8'h50); send_byte(8'h53);
        n_tests++; if (servo_pos !== 16'h9650) begin n_fail++; $display("FAIL expiry_pos: got %h want 9650", servo_pos); end
        wait_tx(mark + 1, ok);
        settle(10);
        n_tests++; if (!ok || tx_log[mark] !== 8'hAB || err_cnt !== 8'd5) begin n_fail++; $display("FAIL expiry_reply: got %h err %0d want ab 5", tx_log[mark], err_cnt); end
    endtask

    task automatic test_trigger();
        int mark;
        int pulses;
        bit ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAE; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h26;
        mark = tx_total;
        pulses = rng_pulses;
        rng_len = 16'h1234;
        send_byte(8'h0C);
        settle(5);
        rng_done = 1'b1;
        wait_tx(mark + 4, ok);
        settle(10);
        rng_done = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL trig_count: got %0d bytes want 4", tx_total - mark); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (tx_log[mark + i] !== exp_b[i]) begin n_fail++; $display("FAIL trig_byte%0d: got %h want %h", i, tx_log[mark + i], exp_b[i]); end
        end
        n_tests++; if (rng_pulses - pulses !== 1) begin n_fail++; $display("FAIL trig_rng_en: got %0d pulses want 1", rng_pulses - pulses); end
    endtask

    task automatic test_trigger_stale();
        int mark;
        bit ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAE; exp_b[1] = 8'hA5; exp_b[2] = 8'h5A; exp_b[3] = 8'hFF;
        mark = tx_total;
        rng_len = 16'hBEEF;
        rng_done = 1'b1;
        send_byte(8'h0C);
        settle(20);
        n_tests++; if (tx_total !== mark) begin n_fail++; $display("FAIL stale_wait: got %0d bytes want 0", tx_total - mark); end
        rng_done = 1'b0;
        rng_len = 16'hA55A;
        settle(3);
        rng_done = 1'b1;
        wait_tx(mark + 4, ok);
        settle(10);
        rng_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (tx_log[mark + i] !== exp_b[i]) begin n_fail++; $display("FAIL stale_byte%0d: got %h want %h", i, tx_log[mark + i], exp_b[i]); end
        end
    endtask

    task automatic test_busy_hold();
        int mark;
        bit ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAE; exp_b[1] = 8'h00; exp_b[2] = 8'hFF; exp_b[3] = 8'hFF;
        mark = tx_total;
        rng_len = 16'h00FF;
        send_byte(8'h0C);
        settle(3);
        rng_done = 1'b1;
        wait_tx(mark + 1, ok);
        busy_force = 1'b1;
        settle(1000);
        n_tests++; if (tx_total !== mark + 1) begin n_fail++; $display("FAIL busy_hold: got %0d bytes want 1", tx_total - mark); end
        busy_force = 1'b0;
        wait_tx(mark + 4, ok);
        settle(10);
        rng_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (tx_log[mark + i] !== exp_b[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h want %h", i, tx_log[mark + i], exp_b[i]); end
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) send_byte(8'h7F);
        settle(40);
        n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", err_cnt); end
        n_tests++; if (servo_pos !== 16'h9650) begin n_fail++; $display("FAIL saturate_pos: got %h want 9650", servo_pos); end
    endtask

    task automatic test_reset_mid();
        int mark;
        bit ok;
        mark = tx_total;
        rng_len = 16'h1234;
        send_byte(8'h0C);
        settle(3);
        rng_done = 1'b1;
        wait_tx(mark + 2, ok);
        rst = 1'b1;
        rng_done = 1'b0;
        settle(1);
        n_tests++; if (tx_send !== 1'b0 || rng_en !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got send %b en %b want 0 0", tx_send, rng_en); end
        n_tests++; if (err_cnt !== 8'd0 || servo_pos !== 16'h9696) begin n_fail++; $display("FAIL midrst_state: got err %0d pos %h want 0 9696", err_cnt, servo_pos); end
        settle(1);
        mark = tx_total;
        rst = 1'b0;
        wait_tx(mark + 1, ok);
        settle(40);
        n_tests++; if (tx_total !== mark + 1 || tx_log[mark] !== 8'hAA) begin n_fail++; $display("FAIL midrst_boot: got %0d bytes first %h want 1 byte aa", tx_total - mark, tx_log[mark]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        tx_total   = 0;
        rng_pulses = 0;
        viol       = 0;
        busy_force = 1'b0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        rng_done   = 1'b0;
        rng_len    = '0;
        @(negedge clk);
        test_reset();
        test_servo_ok();
        test_servo_bad();
        test_init_and_drop();
        test_timeout();
        test_trigger();
        test_trigger_stale();
        test_busy_hold();
        test_err_saturate();
        test_reset_mid();
        n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL send_while_busy: got %0d want 0", viol); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_mc.md
CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 SHALL have parameter N_SERVO, default 2, number of servo channels (1..16).
REQ-002 SHALL have parameter POS_LEN, default 8, servo position width (1..8).
REQ-003 SHALL have parameter POS_DEF, default 150, position loaded on reset/init.
REQ-004 SHALL have parameter CAP_LEN, default 16, ranger length width (multiple of 8, 8..32).
REQ-005 SHALL have parameter RTO_CYC, default 500000, inter-byte timeout in clk cycles (>=2).
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz nominal.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rx_data  input  8  received byte from serial_r.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-010 SHALL have port tx_data  output  8  byte to serial_t.
REQ-011 SHALL have port tx_send  output  1  one-cycle send request.
REQ-012 SHALL have port tx_busy  input  1  serial_t busy.
REQ-013 SHALL have port servo_pos  output  N_SERVO*POS_LEN  channel i at [i*POS_LEN +: POS_LEN].
REQ-014 SHALL have port rng_en  output  1  ranger start pulse.
REQ-015 SHALL have port rng_done  input  1  ranger result valid (level).
REQ-016 SHALL have port rng_len  input  CAP_LEN  ranger measured length.
REQ-017 SHALL have port err_cnt  output  8  saturating count of rejected frames.

Function
REQ-018 SHALL be a single FSM: BOOT, IDLE, SV_CH, SV_POS, SV_SUM, RG_START, RG_WAIT, TX_BYTE, TX_WAIT; all outputs registered.
REQ-019 SHALL, in IDLE, decode rx_valid bytes: 0x00 init, 0x03 servo, 0x0C trigger; any other byte -> reply NAK 0x55, err_cnt+1.
REQ-020 SHALL on init: set every channel to POS_DEF, reply 0xAA.
REQ-021 SHALL on servo: capture channel byte (SV_CH), position byte (SV_POS), checksum byte (SV_SUM); checksum = 0x03 ^ ch ^ pos.
REQ-022 SHALL on valid servo frame (ch < N_SERVO, checksum match): update channel ch with pos[POS_LEN-1:0] on the cycle after the checksum byte, reply 0xAB; other channels unchanged.
REQ-023 SHALL on bad channel or checksum: leave all positions unchanged, reply 0x55, err_cnt+1.
REQ-024 SHALL in SV_CH/SV_POS/SV_SUM count cycles since the last accepted byte; at RTO_CYC with no byte, discard frame, reply 0x55, err_cnt+1; rx_valid on the expiry cycle wins (byte accepted, no timeout).
REQ-025 SHALL on trigger: drive rng_en high one cycle (RG_START), wait in RG_WAIT until rng_done=1 (rng_done already high at entry: wait for it to drop, then rise), latch rng_len.
REQ-026 SHALL reply to trigger with 0xAE, then CAP_LEN/8 length bytes MSB first, then XOR of the length bytes.
REQ-027 SHALL transmit each byte by: TX_BYTE asserts tx_send for exactly one cycle with tx_data stable when tx_busy=0; TX_WAIT holds one guard cycle, then waits for tx_busy=0 before next byte or IDLE.
REQ-028 SHALL ignore rx_valid in BOOT, RG_*, TX_* (dropped, err_cnt+1 per dropped byte).
REQ-029 SHALL saturate err_cnt at 255, no wrap.
REQ-030 SHALL never assert tx_send while tx_busy=1.

Reset
REQ-031 SHALL on rst=1 at a clk edge: state BOOT, all channels POS_DEF, tx_send=0, tx_data=0, rng_en=0, err_cnt=0, latched length 0, timeout counter 0.
REQ-032 SHALL from BOOT send 0xAA once, then enter IDLE.
REQ-033 SHALL abort any frame or transmission on rst mid-operation; tx_send=0 from the next cycle.

Verification
REQ-034 SHALL cover: reset release -> single tx_send with 0xAA, servo_pos all 150.
REQ-035 SHALL cover: bytes 0x03,0x01,0x64,0x66 -> channel 1 = 100, channel 0 = 150, reply 0xAB.
REQ-036 SHALL cover: bytes 0x03,0x01,0x64,0x00 -> positions unchanged, reply 0x55, err_cnt=1; ch=0x05 with N_SERVO=2 likewise.
REQ-037 SHALL cover: 0x0C, rng_done with rng_len=0x1234 -> tx bytes 0xAE,0x12,0x34,0x26; rng_en pulsed exactly once.
REQ-038 SHALL cover: 0x03,0x00 then silence RTO_CYC cycles -> reply 0x55, err_cnt+1, IDLE; byte on the expiry cycle -> accepted.
REQ-039 SHALL cover: tx_busy held high 1000 cycles mid-reply -> no tx_send until low; rst mid-reply -> tx_send 0, 0xAA resent after release.
